// File: rtl/cache_miss_ctrl.sv
// Request controller in front of a 4-line x 4-word direct-mapped cache.
// Read misses fill the whole line from memory; writes are write-through, no write-allocate.
module cache_miss_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [5:0]        i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_done,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_hit,
    output logic              o_busy,
    output logic [5:0]        o_cache_addr,
    output logic [DATA_W-1:0] o_cache_wdata,
    output logic              o_cache_ren,
    output logic              o_cache_wen,
    input  logic              i_cache_hit,
    input  logic [DATA_W-1:0] i_cache_rdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [5:0]        o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [CNT_W-1:0]  o_stat_hits,
    output logic [CNT_W-1:0]  o_stat_misses
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOOKUP   = 3'd1;
    localparam logic [2:0] S_CHECK    = 3'd2;
    localparam logic [2:0] S_FILL_REQ = 3'd3;
    localparam logic [2:0] S_FILL_WR  = 3'd4;
    localparam logic [2:0] S_WR_CACHE = 3'd5;
    localparam logic [2:0] S_WR_MEM   = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    logic [2:0]        r_state;
    logic [5:0]        r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_fill;
    logic              r_hit;
    logic [1:0]        r_wcnt;
    logic [CNT_W-1:0]  r_stat_hits;
    logic [CNT_W-1:0]  r_stat_misses;

    logic [5:0]        w_fill_addr;

    // Line fills always walk words 0..3 of the latched line, independent of the requested offset.
    assign w_fill_addr = {r_addr[5:2], r_wcnt};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_we          <= 1'b0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_fill        <= '0;
            r_hit         <= 1'b0;
            r_wcnt        <= '0;
            r_stat_hits   <= '0;
            r_stat_misses <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cpu_req) begin
                        r_addr  <= i_cpu_addr;
                        r_we    <= i_cpu_we;
                        r_wdata <= i_cpu_wdata;
                        r_rdata <= '0;
                        r_hit   <= 1'b0;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    r_hit <= i_cache_hit;
                    if (!r_we) begin
                        if (i_cache_hit) begin
                            r_rdata <= i_cache_rdata;
                            if (r_stat_hits != '1) begin
                                r_stat_hits <= r_stat_hits + CNT_W'(1);
                            end
                            r_state <= S_DONE;
                        end else begin
                            if (r_stat_misses != '1) begin
                                r_stat_misses <= r_stat_misses + CNT_W'(1);
                            end
                            r_wcnt  <= '0;
                            r_state <= S_FILL_REQ;
                        end
                    end else begin
                        r_state <= i_cache_hit ? S_WR_CACHE : S_WR_MEM;
                    end
                end
                S_FILL_REQ: begin
                    if (i_mem_ack) begin
                        r_fill <= i_mem_rdata;
                        if (r_wcnt == r_addr[1:0]) begin
                            r_rdata <= i_mem_rdata;
                        end
                        r_state <= S_FILL_WR;
                    end
                end
                S_FILL_WR: begin
                    if (r_wcnt == 2'd3) begin
                        r_state <= S_DONE;
                    end else begin
                        r_wcnt  <= r_wcnt + 2'd1;
                        r_state <= S_FILL_REQ;
                    end
                end
                S_WR_CACHE: begin
                    r_state <= S_WR_MEM;
                end
                S_WR_MEM: begin
                    if (i_mem_ack) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_cpu_done    = 1'b0;
        o_cpu_rdata   = '0;
        o_cpu_hit     = 1'b0;
        o_cache_addr  = '0;
        o_cache_wdata = '0;
        o_cache_ren   = 1'b0;
        o_cache_wen   = 1'b0;
        o_mem_req     = 1'b0;
        o_mem_we      = 1'b0;
        o_mem_addr    = '0;
        o_mem_wdata   = '0;
        case (r_state)
            S_LOOKUP: begin
                o_cache_ren  = 1'b1;
                o_cache_addr = r_addr;
            end
            S_FILL_REQ: begin
                o_mem_req  = 1'b1;
                o_mem_addr = w_fill_addr;
            end
            S_FILL_WR: begin
                o_cache_wen   = 1'b1;
                o_cache_addr  = w_fill_addr;
                o_cache_wdata = r_fill;
            end
            S_WR_CACHE: begin
                o_cache_wen   = 1'b1;
                o_cache_addr  = r_addr;
                o_cache_wdata = r_wdata;
            end
            S_WR_MEM: begin
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = r_addr;
                o_mem_wdata = r_wdata;
            end
            S_DONE: begin
                o_cpu_done  = 1'b1;
                o_cpu_hit   = r_hit;
                o_cpu_rdata = r_we ? '0 : r_rdata;
            end
            default: begin
            end
        endcase
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_stat_hits   = r_stat_hits;
    assign o_stat_misses = r_stat_misses;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Bench for cache_miss_ctrl: cache/memory environment, transaction-level reference model,
// per-cycle compare process and a second narrow-counter instance for saturation.
module tb_cache_miss_ctrl;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, env_init;
    logic          cpu_req, cpu_we, cpu_done, cpu_hit, busy;
    logic [5:0]    cpu_addr, cache_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata, cache_wdata, cache_rdata, mem_wdata, mem_rdata;
    logic          cache_ren, cache_wen, cache_hit;
    logic          mem_req, mem_we, mem_ack;
    logic [15:0]   stat_hits, stat_misses;

    cache_miss_ctrl #(.DATA_W(DW), .CNT_W(16)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_done(cpu_done), .o_cpu_rdata(cpu_rdata), .o_cpu_hit(cpu_hit), .o_busy(busy),
        .o_cache_addr(cache_addr), .o_cache_wdata(cache_wdata),
        .o_cache_ren(cache_ren), .o_cache_wen(cache_wen),
        .i_cache_hit(cache_hit), .i_cache_rdata(cache_rdata),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
        .o_stat_hits(stat_hits), .o_stat_misses(stat_misses)
    );

    // Second instance with 2-bit counters; its cache always hits, memory never acks.
    logic          s_req, s_we, s_done, s_hit, s_busy, s_ren, s_wen, s_mreq, s_mwe;
    logic          s_chit = 1'b0;
    logic          s_mack;
    logic [5:0]    s_addr, s_caddr, s_maddr;
    logic [DW-1:0] s_wdata, s_rdata, s_cwdata, s_crdata, s_mwdata, s_mrdata;
    logic [1:0]    s_hits, s_misses;
    assign s_crdata = '0;
    assign s_mrdata = '0;
    assign s_mack   = 1'b0;
    always @(posedge clk) s_chit <= s_ren;

    cache_miss_ctrl #(.DATA_W(DW), .CNT_W(2)) u_sat (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_req(s_req), .i_cpu_we(s_we), .i_cpu_addr(s_addr), .i_cpu_wdata(s_wdata),
        .o_cpu_done(s_done), .o_cpu_rdata(s_rdata), .o_cpu_hit(s_hit), .o_busy(s_busy),
        .o_cache_addr(s_caddr), .o_cache_wdata(s_cwdata),
        .o_cache_ren(s_ren), .o_cache_wen(s_wen),
        .i_cache_hit(s_chit), .i_cache_rdata(s_crdata),
        .o_mem_req(s_mreq), .o_mem_we(s_mwe), .o_mem_addr(s_maddr), .o_mem_wdata(s_mwdata),
        .i_mem_ack(s_mack), .i_mem_rdata(s_mrdata),
        .o_stat_hits(s_hits), .o_stat_misses(s_misses)
    );

    // Environment: cache registers hit/data one cycle after the probe; memory acks after m_delay waits.
    logic          c_valid [4];
    logic [1:0]    c_tag   [4];
    logic [DW-1:0] c_data  [16];
    logic [DW-1:0] m_data  [64];
    int unsigned   m_wait = 0;
    int unsigned   m_delay;
    logic          spur_ack;
    int            cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    always @(posedge clk) begin
        cache_hit   <= 1'b0;
        cache_rdata <= '0;
        if (cache_ren) begin
            cache_hit   <= c_valid[cache_addr[3:2]] && (c_tag[cache_addr[3:2]] == cache_addr[5:4]);
            cache_rdata <= c_data[cache_addr[3:0]];
        end
        if (env_init) begin
            for (int i = 0; i < 4; i++) c_valid[i] <= 1'b0;
        end else if (cache_wen) begin
            c_data[cache_addr[3:0]]  <= cache_wdata;
            c_tag[cache_addr[3:2]]   <= cache_addr[5:4];
            c_valid[cache_addr[3:2]] <= 1'b1;
        end
    end

    assign mem_ack   = (mem_req && (m_wait == m_delay)) || spur_ack;
    assign mem_rdata = m_data[mem_addr];

    always @(posedge clk) begin
        if (rst || !mem_req || mem_ack) m_wait <= 0;
        else                            m_wait <= m_wait + 1;
        if (env_init) begin
            for (int i = 0; i < 64; i++) m_data[i] <= DW'(i * 17);
        end else if (mem_req && mem_we && mem_ack) begin
            m_data[mem_addr] <= mem_wdata;
        end
    end

    // Reference model state and expectations for the transaction in flight
    logic          ref_valid [4];
    logic [1:0]    ref_tag   [4];
    logic [DW-1:0] ref_cache [16];
    logic [DW-1:0] ref_mem   [64];
    int            exp_hits, exp_misses;
    logic          exp_hit;
    logic [DW-1:0] exp_rdata;
    int            exp_lat, exp_mrd, exp_mwr, exp_cwr;

    logic          t_active, t_we;
    logic [5:0]    t_addr;
    logic [DW-1:0] t_wdata;
    int            t0;
    int            n_mrd, n_mwr, n_cwr, n_ren;
    logic          done_seen, l_hit;
    logic [DW-1:0] l_rdata;
    int            l_lat;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic model_txn(input logic we, input logic [5:0] a, input logic [DW-1:0] wd,
                             input int d);
        logic [1:0] ln;
        logic       hit;
        logic [5:0] wa;
        ln  = a[3:2];
        hit = ref_valid[ln] && (ref_tag[ln] == a[5:4]);
        exp_hit = hit; exp_rdata = '0; exp_mrd = 0; exp_mwr = 0; exp_cwr = 0;
        if (!we) begin
            if (hit) begin
                exp_rdata = ref_cache[a[3:0]];
                exp_lat   = 3;
                if (exp_hits < 65535) exp_hits++;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    wa = {a[5:2], 2'(k)};
                    ref_cache[wa[3:0]] = ref_mem[wa];
                end
                ref_valid[ln] = 1'b1;
                ref_tag[ln]   = a[5:4];
                exp_rdata = ref_mem[a];
                exp_lat   = 3 + 4 * (2 + d);
                exp_mrd   = 4;
                exp_cwr   = 4;
                if (exp_misses < 65535) exp_misses++;
            end
        end else begin
            ref_mem[a] = wd;
            exp_mwr    = 1;
            if (hit) begin
                ref_cache[a[3:0]] = wd;
                exp_lat = 5 + d;
                exp_cwr = 1;
            end else begin
                exp_lat = 4 + d;
            end
        end
    endtask

    // Called just after a rising edge; that cycle is cycle 0 of the request.
    task automatic start_txn(input logic we, input logic [5:0] a, input logic [DW-1:0] wd,
                             input int d);
        m_delay = d;
        n_mrd = 0; n_mwr = 0; n_cwr = 0; n_ren = 0; done_seen = 1'b0;
        t_we = we; t_addr = a; t_wdata = wd; t0 = cycle; t_active = 1'b1;
        cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
    endtask

    task automatic finish_txn();
        int k;
        @(posedge clk); #1;
        cpu_addr  = 6'($urandom);
        cpu_wdata = $urandom;
        cpu_we    = ~cpu_we;
        k = 0;
        while (!done_seen && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        chk("done_within_budget", done_seen, 1);
        cpu_req  = 1'b0;
        t_active = 1'b0;
        spur_ack = 1'b0;
    endtask

    task automatic run(input logic we, input logic [5:0] a, input logic [DW-1:0] wd, input int d);
        model_txn(we, a, wd, d);
        start_txn(we, a, wd, d);
        finish_txn();
    endtask

    // Per-cycle compare of DUT outputs against the reference expectations
    logic        p_wait;
    logic [39:0] p_vec;
    initial begin
        p_wait = 1'b0;
        p_vec  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_wait = 1'b0;
            end else begin
                chk("ren_wen_exclusive", cache_ren & cache_wen, 0);
                if (p_wait) chk("mem_req_hold", {mem_req, mem_we, mem_addr, mem_wdata}, p_vec);
                p_wait = mem_req & ~mem_ack;
                p_vec  = {mem_req, mem_we, mem_addr, mem_wdata};
                chk("busy", busy, t_active && (cycle > t0));
                if (!t_active) begin
                    chk("idle_quiet", {cpu_done, cache_ren, cache_wen, mem_req}, 0);
                end else begin
                    if (cache_ren) begin
                        n_ren++;
                        chk("probe_addr", cache_addr, t_addr);
                    end
                    if (cache_wen) begin
                        if (t_we) begin
                            chk("cache_wr_addr", cache_addr, t_addr);
                            chk("cache_wr_data", cache_wdata, t_wdata);
                        end else begin
                            chk("fill_wr_addr", cache_addr, {t_addr[5:2], n_cwr[1:0]});
                            chk("fill_wr_data", cache_wdata, ref_mem[{t_addr[5:2], n_cwr[1:0]}]);
                        end
                        n_cwr++;
                    end
                    if (mem_req && mem_ack) begin
                        chk("mem_dir", mem_we, t_we);
                        if (t_we) begin
                            chk("mem_wr_addr", mem_addr, t_addr);
                            chk("mem_wr_data", mem_wdata, t_wdata);
                            n_mwr++;
                        end else begin
                            chk("mem_rd_addr", mem_addr, {t_addr[5:2], n_mrd[1:0]});
                            n_mrd++;
                        end
                    end
                    if (cpu_done) begin
                        chk("latency", cycle - t0, exp_lat);
                        chk("cpu_hit", cpu_hit, exp_hit);
                        chk("cpu_rdata", cpu_rdata, exp_rdata);
                        chk("stat_hits", stat_hits, exp_hits);
                        chk("stat_misses", stat_misses, exp_misses);
                        chk("mem_reads", n_mrd, exp_mrd);
                        chk("mem_writes", n_mwr, exp_mwr);
                        chk("cache_writes", n_cwr, exp_cwr);
                        chk("probes", n_ren, 1);
                        l_rdata = cpu_rdata; l_hit = cpu_hit; l_lat = cycle - t0;
                        done_seen = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat1;
        logic found;
        rst = 1'b1; env_init = 1'b1; spur_ack = 1'b0; m_delay = 0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
        t_active = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0; t0 = 0;
        done_seen = 1'b0; exp_hits = 0; exp_misses = 0;
        for (int i = 0; i < 4; i++) begin ref_valid[i] = 1'b0; ref_tag[i] = '0; end
        for (int i = 0; i < 64; i++) ref_mem[i] = DW'(i * 17);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; env_init = 1'b0;
        chk("rst_cpu_outs", {cpu_done, cpu_hit, cpu_rdata, busy}, 0);
        chk("rst_cache_outs", {cache_ren, cache_wen, cache_addr, cache_wdata}, 0);
        chk("rst_mem_outs", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
        chk("rst_stats", {stat_hits, stat_misses}, 0);

        // Cold read miss
        run(1'b0, 6'h25, '0, 0);
        chk("s1_rdata", l_rdata, 32'h275);
        chk("s1_hit", l_hit, 0);
        chk("s1_latency", l_lat, 11);
        chk("s1_misses", stat_misses, 1);
        lat1 = l_lat;

        // Read hit, with a stray memory ack that must be ignored
        spur_ack = 1'b1;
        run(1'b0, 6'h27, '0, 0);
        chk("s2_rdata", l_rdata, 32'h297);
        chk("s2_hit", l_hit, 1);
        chk("s2_latency", l_lat, 3);
        chk("s2_hits", stat_hits, 1);

        // Write hit then read back
        run(1'b1, 6'h26, 32'hDEADBEEF, 0);
        chk("s3_wr_hit", l_hit, 1);
        chk("s3_wr_latency", l_lat, 5);
        run(1'b0, 6'h26, '0, 0);
        chk("s3_rd_rdata", l_rdata, 32'hDEADBEEF);
        chk("s3_rd_hit", l_hit, 1);

        // Write miss leaves the resident line alone
        run(1'b1, 6'h35, 32'h12345678, 0);
        chk("s4_wr_hit", l_hit, 0);
        chk("s4_wr_latency", l_lat, 4);
        run(1'b0, 6'h25, '0, 0);
        chk("s4_rd_hit", l_hit, 1);
        chk("s4_rd_rdata", l_rdata, 32'h275);
        run(1'b1, 6'h3C, 32'hCAFEF00D, 3);
        chk("s4_wr_miss_stall_latency", l_lat, 7);

        // Memory stall of 5 cycles per word on a fill
        run(1'b0, 6'h0A, '0, 5);
        chk("s5_rdata", l_rdata, 32'hAA);
        chk("s5_latency", l_lat, 31);
        chk("s5_vs_s1", l_lat - lat1, 20);

        // Reset during the second fill request
        start_txn(1'b0, 6'h33, '0, 2);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(posedge clk); #1;
            if (mem_req && mem_addr == 6'h31) found = 1'b1;
        end
        chk("s6_second_fill_seen", found, 1);
        rst = 1'b1; cpu_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; t_active = 1'b0;
        chk("s6_cpu_outs", {cpu_done, cpu_hit, cpu_rdata, busy}, 0);
        chk("s6_cache_outs", {cache_ren, cache_wen, cache_addr, cache_wdata}, 0);
        chk("s6_mem_outs", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
        chk("s6_stats", {stat_hits, stat_misses}, 0);
        ref_valid[0] = 1'b0;
        exp_hits = 0; exp_misses = 0;
        run(1'b0, 6'h10, '0, 0);
        chk("s6_rd_rdata", l_rdata, 32'h110);
        chk("s6_rd_latency", l_lat, 11);
        chk("s6_rd_misses", stat_misses, 1);

        // Saturation of 2-bit hit counter
        for (int i = 0; i < 5; i++) begin
            logic got;
            s_req = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clk);
                if (s_done) got = 1'b1;
            end
            chk("sat_done", got, 1);
            @(posedge clk); #1;
            s_req = 1'b0;
            if (i == 2) chk("sat_hits_after_3", s_hits, 2'd3);
        end
        chk("sat_hits_after_5", s_hits, 2'd3);
        chk("sat_misses", s_misses, 2'd0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_miss_ctrl.md
Name: cache_miss_ctrl

Overview:
Request controller placed directly upstream of the 4-line x 4-word direct-mapped cache (6-bit word address: tag[5:4], line[3:2], offset[1:0]; 32-bit data). It accepts CPU read/write requests and probes the cache. On a read miss it fetches the full 4-word line from main memory and writes it into the cache. Writes are write-through with no write-allocate.

Parameters:
DATA_W, 32, data width (must match cache)
CNT_W, 16, width of hit/miss statistics counters

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cpu_req  in  1  request; held by CPU until cpu_done
cpu_we  in  1  1=write, 0=read; sampled with cpu_req in IDLE
cpu_addr  in  6  word address
cpu_wdata  in  DATA_W  write data
cpu_done  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data, valid when cpu_done=1 on a read
cpu_hit  out  1  1 if the completed request hit, valid with cpu_done
busy  out  1  1 whenever state!=IDLE
cache_addr  out  6  address to cache
cache_wdata  out  DATA_W  write data to cache
cache_ren  out  1  cache read probe
cache_wen  out  1  cache write
cache_hit  in  1  cache hit, registered by cache, one cycle after cache_ren
cache_rdata  in  DATA_W  cache read data, same timing as cache_hit
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1=memory write
mem_addr  out  6  memory word address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory accepts/completes the current request (one cycle)
mem_rdata  in  DATA_W  memory read data, valid with mem_ack on reads
stat_hits  out  CNT_W  saturating count of read hits
stat_misses  out  CNT_W  saturating count of read misses

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE. All outputs are 0: done, hit, rdata, ren, wen, mem_*, busy, stats. Internal latches and the word counter clear. An in-flight fill or write is abandoned. Cache contents are untouched by this block.
- States: IDLE, LOOKUP, CHECK, FILL_REQ, FILL_WR, WR_CACHE, WR_MEM, DONE.
- IDLE: if cpu_req=1, latch addr/we/wdata and go to LOOKUP.
- LOOKUP: cache_ren=1 and cache_addr=latched addr, for exactly 1 cycle. Go to CHECK.
- CHECK: sample cache_hit/cache_rdata.
  - Read hit: latch rdata, set hit_flag=1, stat_hits+1, go to DONE.
  - Read miss: set hit_flag=0, stat_misses+1, wcnt=0, go to FILL_REQ.
  - Write hit: hit_flag=1, go to WR_CACHE.
  - Write miss: hit_flag=0, go to WR_MEM.
- FILL_REQ: mem_req=1, mem_we=0, mem_addr={tag,line,wcnt}. Hold these until mem_ack. On ack, capture mem_rdata into fill buffer; if wcnt==offset, also latch it as the response data. Go to FILL_WR.
- FILL_WR: cache_wen=1, cache_addr={tag,line,wcnt}, cache_wdata=fill buffer, for 1 cycle. If wcnt==3, go to DONE; else wcnt+1 and go to FILL_REQ. Words are filled in order 0..3 regardless of offset.
- WR_CACHE: cache_wen=1 with latched addr/wdata for 1 cycle, then go to WR_MEM.
- WR_MEM: mem_req=1, mem_we=1, latched addr/wdata, held until mem_ack. Then go to DONE.
- DONE: cpu_done=1, cpu_hit=hit_flag, cpu_rdata=latched data on reads (0 on writes), for 1 cycle. Go to IDLE. A new request is accepted no earlier than the following IDLE cycle.
- Latency from cpu_req in IDLE (cycle 0) to cpu_done:
  - Read hit: cycle 3.
  - Write miss: 4+N cycles, where N = memory wait cycles.
  - Read miss: 2 + 4x(FILL_REQ+FILL_WR) + 1.
- Invariants:
  - cache_ren and cache_wen are never asserted together.
  - mem_req is never dropped before mem_ack.
  - mem_ack outside FILL_REQ/WR_MEM is ignored.
  - Changes to cpu_* inputs while busy are ignored.
- Statistics counters saturate at 2^CNT_W-1, never wrap. Writes are not counted.

Test Plan:
1. Cold read: after rst, read addr 0x25; memory returns (addr x 0x11) with ack delay 0. Required: 4 mem reads at addrs 0x24..0x27, 4 cache writes; cpu_done with rdata=0x275, cpu_hit=0, stat_misses=1.
2. Read hit: re-read 0x27 after scenario 1. Required: cpu_done 3 cycles after req, rdata=0x297, hit=1, no mem_req, stat_hits=1.
3. Write hit: write 0xDEADBEEF to 0x26, then read 0x26. Required: cache_wen and mem write both occur, hit=1, then read returns 0xDEADBEEF as a hit.
4. Write miss: write 0x12345678 to 0x35 (line 1, tag differs). Required: mem write only, no cache_wen, hit=0; a following read of 0x25 still hits.
5. Memory stall: ack delay of 5 cycles per word on a read miss. Required: mem_req and mem_addr stay stable throughout each wait; completion 20 cycles later than scenario 1.
6. Reset mid-fill: assert rst during the 2nd FILL_REQ. Required: next cycle all outputs are 0, state is IDLE, stats are 0; a new read completes normally. Also with CNT_W=2, 5 read hits must leave stat_hits=3.
